// File: rtl/wb2ahb_pkg.sv
// Shared AHB-Lite encodings for the Wishbone-to-AHB bridge.
package wb2ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
endpackage

// File: rtl/wb2ahb.sv
// Wishbone slave to AHB master bridge: one SINGLE word transfer per Wishbone
// cycle, with bounded re-issue on RETRY/SPLIT.
module wb2ahb
  import wb2ahb_pkg::*;
#(
  parameter int AWIDTH    = 16,
  parameter int DWIDTH    = 32,
  parameter int RETRY_MAX = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AWIDTH-1:0] adr_i,
  input  logic [DWIDTH-1:0] dat_i,
  output logic [DWIDTH-1:0] dat_o,
  input  logic              we_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  output logic              ack_o,
  output logic              err_o,
  output logic              hbusreq,
  input  logic              hgrant,
  output logic [AWIDTH-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DWIDTH-1:0] hwdata,
  input  logic [DWIDTH-1:0] hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);
  localparam int CW = $clog2(RETRY_MAX + 1);
  localparam logic [CW-1:0] RMAX = CW'(RETRY_MAX);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_RESP} state_t;

  state_t            state;
  logic [AWIDTH-1:0] adr_q;
  logic [DWIDTH-1:0] dat_q;
  logic              we_q;
  logic [CW-1:0]     retry_cnt;

  assign hsize  = HSIZE_WORD;
  assign hburst = HBURST_SINGLE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      retry_cnt <= '0;
      dat_o     <= '0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      hbusreq   <= 1'b0;
      haddr     <= '0;
      htrans    <= HTRANS_IDLE;
      hwrite    <= 1'b0;
      hwdata    <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        S_IDLE: if (cyc_i && stb_i) begin
          adr_q     <= adr_i;
          dat_q     <= dat_i;
          we_q      <= we_i;
          retry_cnt <= '0;
          hbusreq   <= 1'b1;
          state     <= S_REQ;
        end
        S_REQ: begin
          if (!cyc_i) begin
            hbusreq <= 1'b0;
            state   <= S_IDLE;
          end else if (hgrant && hready) begin
            htrans <= HTRANS_NONSEQ;
            haddr  <= adr_q;
            hwrite <= we_q;
            state  <= S_ADDR;
          end
        end
        S_ADDR: if (hready) begin
          htrans  <= HTRANS_IDLE;
          hbusreq <= 1'b0;
          hwdata  <= dat_q;
          state   <= S_DATA;
        end
        S_DATA: if (hready) begin
          // An abandoned Wishbone cycle still lets the AHB transfer finish,
          // but nothing is reported back.
          case (hresp)
            HRESP_OKAY: begin
              ack_o <= cyc_i;
              if (cyc_i && !we_q) dat_o <= hrdata;
              state <= S_RESP;
            end
            HRESP_ERROR: begin
              err_o <= cyc_i;
              state <= S_RESP;
            end
            default: begin
              if (retry_cnt == RMAX) begin
                err_o <= cyc_i;
                state <= S_RESP;
              end else begin
                retry_cnt <= retry_cnt + 1'b1;
                hbusreq   <= 1'b1;
                state     <= S_REQ;
              end
            end
          endcase
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb2ahb.sv
// Randomized scoreboard bench for wb2ahb with a scripted AHB slave.
module tb_wb2ahb;
  localparam int AW = 16, DW = 32, RMAX = 15;
  localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] adr_i = '0, haddr;
  logic [DW-1:0] dat_i = '0, dat_o, hwdata, hrdata;
  logic we_i = 0, cyc_i = 0, stb_i = 0, ack_o, err_o, hbusreq, hwrite;
  logic hgrant, hready;
  logic [1:0] htrans, hresp;
  logic [2:0] hsize, hburst;

  wb2ahb #(.AWIDTH(AW), .DWIDTH(DW), .RETRY_MAX(RMAX)) dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o), .err_o(err_o),
    .hbusreq(hbusreq), .hgrant(hgrant), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp));

  typedef struct {logic err; logic [DW-1:0] dat;} exp_t;
  typedef struct {logic [1:0] resp; int waits;} issue_t;
  exp_t   sb[$];
  issue_t script[$];

  int total = 0, bad = 0;
  int gdelay = 0, issues = 0, req_cycles = 0, k = 0;
  bit in_data = 0;
  issue_t cur;
  logic [AW-1:0] exp_adr;
  logic [DW-1:0] exp_dat, rdata_v, model_dat = '0;
  logic exp_we;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // AHB slave: grant after gdelay request cycles, then play the script one
  // entry per NONSEQ; non-OKAY responses use the two-cycle form.
  initial begin
    hgrant = 0; hready = 1; hresp = OKAY; hrdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        in_data = 0; script.delete(); req_cycles = 0;
        hgrant = 0; hready = 1; hresp = OKAY;
        continue;
      end
      req_cycles = hbusreq ? req_cycles + 1 : 0;
      hgrant = (req_cycles > gdelay);
      if (in_data) begin
        if (k == 0 && exp_we) chk("hwdata", hwdata, exp_dat);
        if (k < cur.waits) begin hready = 0; hresp = OKAY; end
        else if (cur.resp == OKAY) begin
          hready = 1; hresp = OKAY; hrdata = rdata_v; in_data = 0;
        end else if (k == cur.waits) begin hready = 0; hresp = cur.resp; end
        else begin hready = 1; hresp = cur.resp; in_data = 0; end
        k++;
      end else begin
        hready = 1; hresp = OKAY; hrdata = $urandom;
      end
      if (htrans == NONSEQ && hready) begin
        issues++;
        chk("haddr", haddr, exp_adr);
        chk("hwrite", hwrite, exp_we);
        chk("hbusreq_addr", hbusreq, 1);
        total++;
        if (script.size() == 0) begin
          bad++; $display("FAIL extra_nonseq: got issue %0d expected none", issues);
        end else begin
          cur = script.pop_front(); in_data = 1; k = 0;
        end
      end
    end
  end

  // Monitor: every Wishbone termination is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ack_err_excl", ack_o & err_o, 0);
        chk("htrans_legal", htrans[0], 0);
        chk("hsize", hsize, 3'b010);
        chk("hburst", hburst, 3'b000);
        if (ack_o || err_o) begin
          total++;
          if (sb.size() == 0) begin
            bad++; $display("FAIL unexpected_term: got ack=%0b err=%0b expected none", ack_o, err_o);
          end else begin
            e = sb.pop_front();
            chk("err_o", err_o, e.err);
            chk("ack_o", ack_o, !e.err);
            chk("dat_o", dat_o, e.dat);
          end
        end
      end
    end
  end

  task automatic start(logic we, logic [AW-1:0] adr, logic [DW-1:0] dat,
                       logic [DW-1:0] rd, int gd);
    exp_adr = adr; exp_dat = dat; exp_we = we; rdata_v = rd; gdelay = gd; issues = 0;
    @(posedge clk); #1;
    cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = dat;
    @(posedge clk);
  endtask

  task automatic drop();
    #1 cyc_i = 0; stb_i = 0; adr_i = $urandom; dat_i = $urandom; we_i = $urandom_range(1);
  endtask

  task automatic wait_data();
    int t = 0;
    while (!in_data && t < 100) begin @(posedge clk); #2; t++; end
    chk("reach_data", in_data, 1);
  endtask

  // nret RETRY/SPLITs before the final response; w<0 picks random waits.
  task automatic run_txn(logic we, logic [AW-1:0] adr, logic [DW-1:0] dat,
                         logic [DW-1:0] rd, int gd, int nret, logic [1:0] fin,
                         int w, int exp_lat);
    int n_retry, n_iss, lat;
    logic err;
    issue_t it;
    n_retry = (nret > RMAX) ? RMAX + 1 : nret;
    n_iss   = (nret > RMAX) ? RMAX + 1 : nret + 1;
    err     = (nret > RMAX) || (fin == ERROR);
    for (int i = 0; i < n_retry; i++) begin
      it.resp = $urandom_range(1) ? RETRY : SPLIT;
      it.waits = (w >= 0) ? w : $urandom_range(3);
      script.push_back(it);
    end
    if (nret <= RMAX) begin
      it.resp = fin; it.waits = (w >= 0) ? w : $urandom_range(3);
      script.push_back(it);
    end
    if (!err && !we) model_dat = rd;
    sb.push_back('{err, model_dat});
    start(we, adr, dat, rd, gd);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!(ack_o || err_o) && lat < 3000);
    chk("terminated_in_time", lat >= 3000, 0);
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    @(posedge clk); drop();
    chk("nonseq_count", issues, n_iss);
    chk("script_left", script.size(), 0);
  endtask

  initial begin
    issue_t it;
    logic [DW-1:0] held;
    int r, nret;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_htrans", htrans, 0); chk("rst_hbusreq", hbusreq, 0);
    chk("rst_ack", ack_o, 0); chk("rst_err", err_o, 0);
    chk("rst_haddr", haddr, 0); chk("rst_hwrite", hwrite, 0);
    chk("rst_hwdata", hwdata, 0); chk("rst_dat_o", dat_o, 0);
    chk("rst_hsize", hsize, 3'b010); chk("rst_hburst", hburst, 3'b000);
    @(posedge clk); #2 rst = 0;

    run_txn(1, 16'h0040, 32'hCAFE_F00D, 32'h0, 0, 0, OKAY, 0, 4);
    run_txn(0, 16'h0100, 32'h0, 32'h1234_5678, 0, 0, OKAY, 3, 7);
    run_txn(0, 16'h0200, 32'h0, 32'hDEAD_BEEF, 0, 0, ERROR, 0, 5);
    run_txn(0, 16'h0300, 32'h0, 32'hA5A5_0001, 0, 2, OKAY, 0, 0);
    run_txn(1, 16'h0304, 32'h5555_AAAA, 32'h0, 0, 16, OKAY, 0, 0);

    // Grant withheld, then the master gives up.
    start(0, 16'h0400, 32'h0, 32'h0, 1000);
    repeat (9) @(posedge clk);
    @(negedge clk); chk("abandon_hbusreq_before", hbusreq, 1);
    @(posedge clk); drop();
    @(posedge clk); @(negedge clk);
    chk("abandon_hbusreq", hbusreq, 0); chk("abandon_htrans", htrans, 0);
    repeat (5) @(posedge clk);
    chk("abandon_nonseq", issues, 0);
    gdelay = 0;
    run_txn(0, 16'h0404, 32'h0, 32'h0BAD_CAFE, 0, 0, OKAY, 1, 5);

    // Master drops cyc_i during the data phase: transfer finishes silently.
    held = model_dat;
    it.resp = OKAY; it.waits = 4; script.push_back(it);
    start(0, 16'h0500, 32'h0, ~held, 0);
    wait_data(); drop();
    repeat (10) @(posedge clk);
    chk("drop_nonseq", issues, 1); chk("drop_dat_o", dat_o, held);
    chk("drop_script_left", script.size(), 0);

    // Reset in the middle of the data phase.
    it.resp = OKAY; it.waits = 6; script.push_back(it);
    start(0, 16'h0600, 32'h0, 32'h7777_7777, 0);
    wait_data();
    rst = 1; cyc_i = 0; stb_i = 0;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_htrans", htrans, 0); chk("mid_rst_hbusreq", hbusreq, 0);
    chk("mid_rst_ack", ack_o, 0); chk("mid_rst_err", err_o, 0);
    chk("mid_rst_dat_o", dat_o, 0); chk("mid_rst_haddr", haddr, 0);
    model_dat = '0;
    @(posedge clk); #2 rst = 0;
    run_txn(0, 16'h0604, 32'h0, 32'h0F0F_1234, 0, 0, OKAY, 0, 4);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(19);
      nret = (r < 12) ? 0 : (r < 18) ? $urandom_range(3, 1) : 16 + $urandom_range(2);
      run_txn($urandom_range(1), AW'($urandom), $urandom, $urandom,
              $urandom_range(3), nret, ($urandom_range(4) == 0) ? ERROR : OKAY, -1, 0);
    end
    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
